// File: rtl/burst_write_master_nuc_if.sv
// rtl/burst_write_master_nuc_if.sv - AXI4 write-channel bundle for the NUC burst write master
//
// Purpose: groups the AW, W and B channels of one AXI4 write port.
// Ports (modport master = the burst master side, slave = the memory side):
//   AW: awaddr, awlen, awsize, awburst, awcache, awprot, awvalid (master out), awready (master in)
//   W : wdata, wstrb, wlast, wvalid (master out), wready (master in)
//   B : bresp, bvalid (master in), bready (master out)

interface burst_write_master_nuc_if #(
  parameter int DATAWIDTH       = 64,
  parameter int ADDRESSWIDTH    = 32,
  parameter int BYTEENABLEWIDTH = 8
);
  logic [ADDRESSWIDTH-1:0]    awaddr;
  logic [7:0]                 awlen;
  logic [2:0]                 awsize;
  logic [1:0]                 awburst;
  logic [3:0]                 awcache;
  logic [2:0]                 awprot;
  logic                       awvalid;
  logic                       awready;
  logic [DATAWIDTH-1:0]       wdata;
  logic [BYTEENABLEWIDTH-1:0] wstrb;
  logic                       wlast;
  logic                       wvalid;
  logic                       wready;
  logic [1:0]                 bresp;
  logic                       bvalid;
  logic                       bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/burst_write_master_nuc.sv
// rtl/burst_write_master_nuc.sv - AXI4 INCR burst write master with internal FWFT FIFO
//
// Purpose: user logic pushes words into a FIFO; the block drains them to memory as
// INCR bursts from control_write_base for control_write_length bytes, one burst
// outstanding at a time, never crossing a MAXBURSTCOUNT-beat aligned boundary.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   control_write_base/length/go       transfer setup and one-cycle start pulse
//   control_done, control_error        idle-and-complete flag, sticky BRESP error
//   user_write_buffer/buffer_data      FIFO push strobe and data
//   user_buffer_full                   FIFO full (push while full is dropped unless a pop coincides)
//   m_axi                              AXI4 write channels (master modport)

module burst_write_master_nuc #(
  parameter int DATAWIDTH       = 64,
  parameter int ADDRESSWIDTH    = 32,
  parameter int MAXBURSTCOUNT   = 8,
  parameter int BURSTCOUNTWIDTH = 4,
  parameter int BYTEENABLEWIDTH = 8,
  parameter int FIFODEPTH       = 32,
  parameter int FIFODEPTH_LOG2  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRESSWIDTH-1:0] control_write_base,
  input  logic [ADDRESSWIDTH-1:0] control_write_length,
  input  logic                    control_go,
  output logic                    control_done,
  output logic                    control_error,
  input  logic                    user_write_buffer,
  input  logic [DATAWIDTH-1:0]    user_buffer_data,
  output logic                    user_buffer_full,
  burst_write_master_nuc_if.master m_axi
);

  localparam int BEW_LOG2 = $clog2(BYTEENABLEWIDTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CALC     = 3'd1;
  localparam logic [2:0] S_WAITDATA = 3'd2;
  localparam logic [2:0] S_ADDR     = 3'd3;
  localparam logic [2:0] S_DATA     = 3'd4;
  localparam logic [2:0] S_RESP     = 3'd5;

  localparam logic [FIFODEPTH_LOG2-1:0]  PTR_ONE  = 1;
  localparam logic [FIFODEPTH_LOG2:0]    CNT_ONE  = 1;
  localparam logic [FIFODEPTH_LOG2:0]    CNT_FULL = FIFODEPTH;
  localparam logic [BURSTCOUNTWIDTH-1:0] BCW_ONE  = 1;
  localparam logic [ADDRESSWIDTH-1:0]    OFF_MASK = MAXBURSTCOUNT - 1;
  localparam logic [ADDRESSWIDTH-1:0]    MAX_BC   = MAXBURSTCOUNT;
  localparam logic [ADDRESSWIDTH-1:0]    LOW_MASK = BYTEENABLEWIDTH - 1;

  logic [2:0]                 r_state;
  logic [ADDRESSWIDTH-1:0]    r_address;
  logic [ADDRESSWIDTH-1:0]    r_length;
  logic [BURSTCOUNTWIDTH-1:0] r_burst;
  logic [BURSTCOUNTWIDTH-1:0] r_beat;
  logic                       r_error;

  logic [DATAWIDTH-1:0]       r_mem [FIFODEPTH];
  logic [FIFODEPTH_LOG2-1:0]  r_wptr;
  logic [FIFODEPTH_LOG2-1:0]  r_rptr;
  logic [FIFODEPTH_LOG2:0]    r_count;

  logic                       w_full;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_last;
  logic [BURSTCOUNTWIDTH-1:0] w_burst_m1;
  logic [ADDRESSWIDTH-1:0]    w_off;
  logic [ADDRESSWIDTH-1:0]    w_room;
  logic [ADDRESSWIDTH-1:0]    w_words;
  logic [ADDRESSWIDTH-1:0]    w_burst_calc;
  logic [ADDRESSWIDTH-1:0]    w_step;

  // FIFO status. wvalid is only raised once the whole burst is buffered, so a
  // pop in DATA always finds a word at the head.
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = (r_state == S_DATA) && m_axi.wready;
  // A pop frees a slot in the same cycle, so a push into a full FIFO is kept then.
  assign w_push  = user_write_buffer && (!w_full || w_pop);

  // Burst sizing: stop at the next MAXBURSTCOUNT-beat boundary or at the end of the transfer.
  assign w_off        = (r_address >> BEW_LOG2) & OFF_MASK;
  assign w_room       = MAX_BC - w_off;
  assign w_words      = r_length >> BEW_LOG2;
  assign w_burst_calc = (w_room < w_words) ? w_room : w_words;
  assign w_step       = ADDRESSWIDTH'(r_burst) << BEW_LOG2;

  assign w_burst_m1 = r_burst - BCW_ONE;
  assign w_last     = (r_beat == w_burst_m1);

  assign control_done     = (r_state == S_IDLE) && (r_length == '0);
  assign control_error    = r_error;
  assign user_buffer_full = w_full;

  assign m_axi.awaddr  = r_address;
  assign m_axi.awlen   = 8'(w_burst_m1);
  assign m_axi.awsize  = 3'(BEW_LOG2);
  assign m_axi.awburst = 2'b01;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = (r_state == S_ADDR);
  assign m_axi.wdata   = r_mem[r_rptr];
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = (r_state == S_DATA) && w_last;
  assign m_axi.wvalid  = (r_state == S_DATA);
  assign m_axi.bready  = (r_state == S_RESP);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= user_buffer_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_address <= '0;
      r_length  <= '0;
      r_burst   <= '0;
      r_beat    <= '0;
      r_error   <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (control_go) begin
            r_address <= control_write_base;
            r_length  <= control_write_length & ~LOW_MASK;
            r_error   <= 1'b0;
          end else if (r_length != '0) begin
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_burst <= BURSTCOUNTWIDTH'(w_burst_calc);
          r_beat  <= '0;
          r_state <= S_WAITDATA;
        end
        S_WAITDATA: begin
          if (r_count >= (FIFODEPTH_LOG2 + 1)'(r_burst)) begin
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (m_axi.awready) begin
            r_address <= r_address + w_step;
            r_length  <= r_length - w_step;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (m_axi.wready) begin
            if (w_last) begin
              r_beat  <= '0;
              r_state <= S_RESP;
            end else begin
              r_beat <= r_beat + BCW_ONE;
            end
          end
        end
        S_RESP: begin
          if (m_axi.bvalid) begin
            if (m_axi.bresp != 2'b00) begin
              r_error <= 1'b1;
            end
            r_state <= (r_length != '0) ? S_CALC : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_write_master_nuc.sv
// tb/tb_burst_write_master_nuc.sv - self-checking bench for burst_write_master_nuc

module tb_burst_write_master_nuc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] control_write_base = '0;
  logic [31:0] control_write_length = '0;
  logic        control_go = 1'b0;
  logic        control_done;
  logic        control_error;
  logic        user_write_buffer = 1'b0;
  logic [63:0] user_buffer_data = '0;
  logic        user_buffer_full;

  burst_write_master_nuc_if #(.DATAWIDTH(64), .ADDRESSWIDTH(32), .BYTEENABLEWIDTH(8)) axi ();

  burst_write_master_nuc dut (
    .clk                  (clk),
    .reset                (reset),
    .control_write_base   (control_write_base),
    .control_write_length (control_write_length),
    .control_go           (control_go),
    .control_done         (control_done),
    .control_error        (control_error),
    .user_write_buffer    (user_write_buffer),
    .user_buffer_data     (user_buffer_data),
    .user_buffer_full     (user_buffer_full),
    .m_axi                (axi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave-side state
  bit          bp = 1'b0;
  int          err_idx = -1;
  int          resp_idx = 0;
  int          pending_b = 0;
  bit          b_fire_prev = 1'b0;
  bit          aw_hold = 1'b0;
  bit          w_hold = 1'b0;
  logic [31:0] aw_addr_h;
  logic [7:0]  aw_len_h;
  logic [63:0] w_data_h;
  logic        w_last_h;

  logic [31:0] obs_addr[$];
  logic [7:0]  obs_len[$];
  logic [63:0] obs_data[$];
  logic        obs_last[$];

  // Reference model
  logic [31:0] exp_addr[$];
  logic [7:0]  exp_len[$];
  logic        exp_last[$];
  logic [63:0] exp_data[$];

  // Memory slave: decides readies at the falling edge and logs the handshakes that
  // will complete on the following rising edge.
  always @(negedge clk) begin
    if (reset) begin
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bvalid  = 1'b0;
      axi.bresp   = 2'b00;
      pending_b   = 0;
      b_fire_prev = 1'b0;
      aw_hold     = 1'b0;
      w_hold      = 1'b0;
    end else begin
      if (aw_hold) begin
        checks++;
        assert (axi.awvalid === 1'b1 && axi.awaddr === aw_addr_h && axi.awlen === aw_len_h)
        else begin
          errors++;
          $error("FAIL aw_stable observed v=%0b a=%0h l=%0h expected v=1 a=%0h l=%0h",
                 axi.awvalid, axi.awaddr, axi.awlen, aw_addr_h, aw_len_h);
        end
      end
      if (w_hold) begin
        checks++;
        assert (axi.wvalid === 1'b1 && axi.wdata === w_data_h && axi.wlast === w_last_h)
        else begin
          errors++;
          $error("FAIL w_stable observed v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                 axi.wvalid, axi.wdata, axi.wlast, w_data_h, w_last_h);
        end
      end
      if (b_fire_prev) begin
        axi.bvalid = 1'b0;
        pending_b--;
        resp_idx++;
      end
      if (!axi.bvalid && pending_b > 0 && (!bp || $urandom_range(0, 1) == 1)) begin
        axi.bvalid = 1'b1;
        axi.bresp  = (resp_idx == err_idx) ? 2'b10 : 2'b00;
      end
      axi.awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axi.awvalid && axi.awready) begin
        obs_addr.push_back(axi.awaddr);
        obs_len.push_back(axi.awlen);
      end
      aw_hold   = axi.awvalid && !axi.awready;
      aw_addr_h = axi.awaddr;
      aw_len_h  = axi.awlen;
      if (axi.wvalid && axi.wready) begin
        obs_data.push_back(axi.wdata);
        obs_last.push_back(axi.wlast);
        if (axi.wlast) pending_b++;
      end
      w_hold      = axi.wvalid && !axi.wready;
      w_data_h    = axi.wdata;
      w_last_h    = axi.wlast;
      b_fire_prev = axi.bvalid && axi.bready;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Split a transfer into bursts from the address/length rules with plain arithmetic.
  task automatic build_model(input logic [31:0] base, input logic [31:0] len);
    int unsigned a, rem, off, b;
    exp_addr.delete();
    exp_len.delete();
    exp_last.delete();
    a   = base;
    rem = len / 8;
    while (rem > 0) begin
      off = (a / 8) % 8;
      b   = (8 - off < rem) ? 8 - off : rem;
      exp_addr.push_back(a);
      exp_len.push_back(8'(b - 1));
      for (int k = 0; k < int'(b); k++) exp_last.push_back(k == int'(b) - 1);
      a   += b * 8;
      rem -= b;
    end
  endtask

  task automatic push_word(input logic [63:0] d, input bit wait_space);
    int n = 0;
    while (wait_space && user_buffer_full && n < 5000) begin
      tick();
      n++;
    end
    if (wait_space) chk("push_wait_bound", 64'(n < 5000), 64'd1);
    user_write_buffer = 1'b1;
    user_buffer_data  = d;
    if (!user_buffer_full || (axi.wvalid && axi.wready)) exp_data.push_back(d);
    tick();
    user_write_buffer = 1'b0;
  endtask

  task automatic go(input logic [31:0] b, input logic [31:0] l);
    control_write_base   = b;
    control_write_length = l;
    control_go           = 1'b1;
    tick();
    control_go = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (control_done !== 1'b1 && n < 20000) begin
      tick();
      n++;
    end
    chk("done_rise", 64'(control_done), 64'd1);
  endtask

  task automatic compare_xfer(input string tag);
    chk({tag, "_aw_count"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      chk({tag, "_awaddr"}, 64'(obs_addr[i]), 64'(exp_addr[i]));
      chk({tag, "_awlen"}, 64'(obs_len[i]), 64'(exp_len[i]));
    end
    chk({tag, "_w_count"}, 64'(obs_data.size()), 64'(exp_last.size()));
    for (int i = 0; i < obs_data.size() && i < exp_last.size(); i++) begin
      if (exp_data.size() > 0) chk({tag, "_wdata"}, obs_data[i], exp_data.pop_front());
      else chk({tag, "_wdata_unexpected"}, obs_data[i], 64'hx);
      chk({tag, "_wlast"}, 64'(obs_last[i]), 64'(exp_last[i]));
    end
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [31:0] len,
                            input bit bp_i, input int err_i);
    build_model(base, len);
    obs_addr.delete();
    obs_len.delete();
    obs_data.delete();
    obs_last.delete();
    bp       = bp_i;
    err_idx  = err_i;
    resp_idx = 0;
    go(base, len);
    chk("done_drop", 64'(control_done), 64'd0);
    chk("err_clear", 64'(control_error), 64'd0);
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] base, input logic [31:0] len,
                          input int nwords, input bit bp_i, input int err_i);
    start_xfer(base, len, bp_i, err_i);
    for (int i = 0; i < nwords; i++) push_word({$urandom, $urandom}, 1'b1);
    wait_done();
    compare_xfer(tag);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_done", 64'(control_done), 64'd1);
    chk("rst_error", 64'(control_error), 64'd0);
    chk("rst_awvalid", 64'(axi.awvalid), 64'd0);
    chk("rst_wvalid", 64'(axi.wvalid), 64'd0);
    chk("rst_bready", 64'(axi.bready), 64'd0);
    chk("rst_full", 64'(user_buffer_full), 64'd0);
    chk("rst_awaddr", 64'(axi.awaddr), 64'd0);
    reset = 1'b0;
    tick();
    chk("const_awburst", 64'(axi.awburst), 64'd1);
    chk("const_awsize", 64'(axi.awsize), 64'd3);
    chk("const_awcache", 64'(axi.awcache), 64'd3);
    chk("const_awprot", 64'(axi.awprot), 64'd0);
    chk("const_wstrb", 64'(axi.wstrb), 64'hff);

    // Two aligned full bursts.
    run_xfer("aligned", 32'h1000, 32'd128, 16, 1'b0, -1);
    chk("aligned_second_addr", 64'(obs_addr.size() > 1 ? obs_addr[1] : 32'h0), 64'h1040);

    // Start three beats into an 8-beat window.
    run_xfer("offset", 32'h1018, 32'd64, 8, 1'b0, -1);
    chk("offset_first_len", 64'(obs_len.size() > 0 ? obs_len[0] : 8'hff), 64'd4);

    // Burst held back until all of its words are buffered.
    start_xfer(32'h3000, 32'd24, 1'b0, -1);
    push_word({$urandom, $urandom}, 1'b1);
    push_word({$urandom, $urandom}, 1'b1);
    repeat (20) tick();
    chk("starved_no_aw", 64'(obs_addr.size()), 64'd0);
    chk("starved_awvalid", 64'(axi.awvalid), 64'd0);
    push_word({$urandom, $urandom}, 1'b1);
    wait_done();
    compare_xfer("starved");

    // Length low bits ignored, plus a zero-length go.
    run_xfer("lowbits", 32'h4000, 32'd69, 8, 1'b0, -1);
    go(32'h500, 32'd0);
    chk("zero_len_done", 64'(control_done), 64'd1);
    repeat (5) tick();
    chk("zero_len_awvalid", 64'(axi.awvalid), 64'd0);

    // Fill the FIFO past capacity: the extra push is dropped.
    for (int i = 0; i < 33; i++) push_word({$urandom, $urandom}, 1'b0);
    chk("fifo_full", 64'(user_buffer_full), 64'd1);
    chk("fifo_model_depth", 64'(exp_data.size()), 64'd32);
    run_xfer("full", 32'h8000, 32'd256, 0, 1'b0, -1);
    chk("full_cleared", 64'(user_buffer_full), 64'd0);

    // Random back-pressure on all three channels.
    run_xfer("backpressure", 32'h2_0000, 32'd512, 64, 1'b1, -1);

    // Error response on the first of two bursts.
    run_xfer("bresp_err", 32'h1000, 32'd128, 16, 1'b0, 0);
    chk("error_sticky", 64'(control_error), 64'd1);
    repeat (3) tick();
    chk("error_held", 64'(control_error), 64'd1);
    run_xfer("after_err", 32'h1200, 32'd64, 8, 1'b1, -1);
    chk("error_stays_clear", 64'(control_error), 64'd0);

    // Reset in the third data beat.
    start_xfer(32'h2000, 32'd128, 1'b0, -1);
    for (int i = 0; i < 16; i++) push_word({$urandom, $urandom}, 1'b1);
    begin
      int n = 0;
      while (!(obs_data.size() >= 3 && axi.wvalid) && n < 2000) begin
        tick();
        n++;
      end
      chk("reach_beat3", 64'(n < 2000), 64'd1);
    end
    reset = 1'b1;
    #1;
    chk("midrst_wvalid", 64'(axi.wvalid), 64'd0);
    chk("midrst_done", 64'(control_done), 64'd1);
    chk("midrst_full", 64'(user_buffer_full), 64'd0);
    chk("midrst_awvalid", 64'(axi.awvalid), 64'd0);
    exp_data.delete();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    run_xfer("post_reset", 32'h100, 32'd64, 8, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_write_master_nuc.md
Name: burst_write_master_nuc

Overview:
AXI4 write burst master for the NUC path, the write-side counterpart of the NUC read master. User logic pushes DATAWIDTH words into an internal synchronous FIFO. The block drains that FIFO to memory as INCR bursts starting at control_write_base, for control_write_length bytes. Used to write corrected frames and coefficient tables back to DDR.

Parameters:
DATAWIDTH, 64, AXI data width and user word width in bits.
ADDRESSWIDTH, 32, AXI address width.
MAXBURSTCOUNT, 8, maximum beats per burst (power of 2).
BURSTCOUNTWIDTH, 4, width of the internal beat counter; must hold MAXBURSTCOUNT.
BYTEENABLEWIDTH, 8, bytes per beat (DATAWIDTH/8).
FIFODEPTH, 32, internal FIFO depth in words; must be at least MAXBURSTCOUNT.
FIFODEPTH_LOG2, 5, log2(FIFODEPTH).

Ports:
clk  in  1  single clock for all logic.
reset  in  1  asynchronous, active-high reset.
control_write_base  in  ADDRESSWIDTH  start byte address; must be BYTEENABLEWIDTH-aligned.
control_write_length  in  ADDRESSWIDTH  byte count; low log2(BYTEENABLEWIDTH) bits are ignored.
control_go  in  1  one-cycle start pulse.
control_done  out  1  high when idle with all data written and responded.
control_error  out  1  sticky; set on any BRESP other than 2'b00.
user_write_buffer  in  1  push user_buffer_data into the FIFO.
user_buffer_data  in  DATAWIDTH  write data.
user_buffer_full  out  1  FIFO full; a push while full is dropped.
m_axi_awaddr/awlen/awsize/awburst/awcache/awprot/awvalid  out  ADDRESSWIDTH/8/3/2/4/3/1  AW channel.
m_axi_awready  in  1
m_axi_wdata/wstrb/wlast/wvalid  out  DATAWIDTH/BYTEENABLEWIDTH/1/1  W channel.
m_axi_wready  in  1
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1

Behaviour:
- Reset values: control_done=1, control_error=0, all *valid=0, bready=0, user_buffer_full=0, FIFO empty, address=0, length=0. FSM state is IDLE.
- Constant outputs: awburst=2'b01, awsize=log2(BYTEENABLEWIDTH), awcache=4'b0011, awprot=3'b000, wstrb=all ones.
- control_go is accepted only in IDLE. In that cycle: address<=base, length<=length input with low bits cleared, control_error<=0. control_go in any other state is ignored. The FIFO is not flushed by control_go.
- FSM states:
  - IDLE: go to CALC when length!=0.
  - CALC: one cycle. Compute the burst count:
    - off = (address/BYTEENABLEWIDTH) & (MAXBURSTCOUNT-1)
    - words = length/BYTEENABLEWIDTH
    - burst = min(MAXBURSTCOUNT-off, words)
    Register burst; go to WAITDATA.
  - WAITDATA: go to ADDR when the FIFO count is at least burst, so wvalid never stalls mid-burst.
  - ADDR: awvalid=1, awaddr=address, awlen=burst-1. On awready: address+=burst*BYTEENABLEWIDTH, length-=burst*BYTEENABLEWIDTH, go to DATA.
  - DATA: wvalid=1 with wdata taken from the FIFO head (first-word-fall-through). Each wvalid&wready pops one word and increments the beat count. wlast=1 on beat burst-1. On a handshake with wlast, go to RESP.
  - RESP: bready=1. On bvalid: if bresp!=0, set control_error. Go to CALC if length!=0, else IDLE.
- One burst is outstanding at a time. AW completes before W starts; no write interleaving.
- awvalid and wvalid, once asserted, hold with stable payload until the handshake completes.
- control_done=1 only in IDLE with length==0. It drops in the cycle after an accepted control_go with nonzero length. A zero-length go keeps done=1.
- FIFO is synchronous, FIFODEPTH words. A push and pop in the same cycle is allowed, including when full. user_buffer_full is combinational on the count.
- Bursts never cross a MAXBURSTCOUNT*BYTEENABLEWIDTH boundary, which also satisfies the AXI 4 KB rule.
- Reset mid-burst returns to reset values immediately. Outstanding AXI transactions are abandoned, and the interconnect must be reset together with this block.

Test Plan:
- Base 0x1000, length 128, 16 words pushed, slave always ready → 2 bursts (awaddr 0x1000/0x1040, awlen 7 each), data in push order, wlast on beats 8 and 16, done rises after the 2nd bresp.
- Base 0x1018 (off=3), length 64 → bursts of awlen 4 (5 beats @0x1018) then awlen 2 (3 beats @0x1040).
- Length 24 (3 words), only 2 words pushed → no awvalid until the 3rd push; then one burst with awlen=2.
- Random wready/awready/bvalid back-pressure, 512-byte transfer → payload held stable while valid is high, all 64 words intact, done=1 at end.
- bresp=2'b10 on the 1st of 2 bursts → control_error=1 and stays set; transfer still completes; next control_go clears it.
- Reset asserted in DATA beat 3 → wvalid=0, done=1, FIFO empty. A new go of 64 bytes then completes normally.
